pipe_hazard_ctrl: RTL

//  Pipeline sequencer for the 5-stage core. Drives PC write, IF/ID write/flush and the ID/EX STALL (bubble) input.

---
 rtl/cpu_pipe_pkg.sv | 11 +
 rtl/pipe_hazard_ctrl_if.sv | 34 +++
 rtl/sat_counter.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 95 +++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline-control definitions: mult/div FSM encoding and the hardwired zero register.
package cpu_pipe_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID/EX hazard inputs and pipeline control outputs of the hazard sequencer.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);

  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_md_start;
  logic             id_md_read;
  logic             ex_memr;
  logic             ex_regw;
  logic [4:0]       ex_rd;
  logic             br_taken;
  logic             pc_wr;
  logic             if_id_wr;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_md_start, id_md_read,
           ex_memr, ex_regw, ex_rd, br_taken,
    input  pc_wr, if_id_wr, if_id_flush, id_ex_stall, md_busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_md_start, id_md_read,
           ex_memr, ex_regw, ex_rd, br_taken,
    output pc_wr, if_id_wr, if_id_flush, id_ex_stall, md_busy, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use bubbles, branch flushes and mult/div occupancy tracking.
//   state   | meaning
//   RUN     | mult/div unit idle, a new op may issue
//   MD_BUSY | op in flight, md_cnt counts down remaining busy cycles
module pipe_hazard_ctrl #(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave hz
);
  import cpu_pipe_pkg::*;

  localparam int MD_CW = $clog2(MD_LAT + 1);

  md_state_t        state_q, state_d;
  logic [MD_CW-1:0] md_cnt_q, md_cnt_d;
  logic             md_busy, load_use, md_hold, stall, md_go;

  assign md_busy  = (state_q == MD_BUSY);
  assign load_use = hz.ex_memr & hz.ex_regw & (hz.ex_rd != REG_ZERO) &
                    ((hz.id_uses_rs & (hz.id_rs == hz.ex_rd)) |
                     (hz.id_uses_rt & (hz.id_rt == hz.ex_rd)));
  assign md_hold  = md_busy & (hz.id_md_read | hz.id_md_start);
  assign stall    = (load_use | md_hold) & ~hz.br_taken;
  assign md_go    = hz.id_md_start & ~stall & ~hz.br_taken & ~md_busy;

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      RUN: begin
        if (md_go) begin
          state_d  = MD_BUSY;
          md_cnt_d = MD_CW'(MD_LAT - 1);
        end
      end
      MD_BUSY: begin
        md_cnt_d = md_cnt_q - MD_CW'(1);
        if (md_cnt_q == MD_CW'(1)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Branch flush outranks any stall; reset holds the front end frozen with a bubble.
  always_comb begin
    hz.pc_wr       = 1'b1;
    hz.if_id_wr    = 1'b1;
    hz.if_id_flush = 1'b0;
    hz.id_ex_stall = 1'b0;
    if (hz.br_taken) begin
      hz.if_id_flush = 1'b1;
      hz.id_ex_stall = 1'b1;
    end else if (stall) begin
      hz.pc_wr       = 1'b0;
      hz.if_id_wr    = 1'b0;
      hz.id_ex_stall = 1'b1;
    end
    if (!rst_n) begin
      hz.pc_wr       = 1'b0;
      hz.if_id_wr    = 1'b0;
      hz.if_id_flush = 1'b1;
      hz.id_ex_stall = 1'b1;
    end
  end

  assign hz.md_busy = md_busy;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .inc   (stall),
    .cnt   (hz.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .inc   (hz.br_taken),
    .cnt   (hz.flush_cnt)
  );

endmodule
